// File: rtl/rect_pkg.sv
// Shared types and helpers for the rectangle fill scanner.
package rect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  // Smaller of two unsigned values, used to clip the far rectangle edge.
  function automatic int unsigned clip_min(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/rect_clip.sv
// Combinational clipping of a rectangle request against the screen: yields the
// last column/row actually visible and flags regions that contain no pixels.
module rect_clip
  import rect_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic [X_W-1:0] x0_i,
  input  logic [Y_W-1:0] y0_i,
  input  logic [X_W-1:0] width_i,
  input  logic [Y_W-1:0] height_i,
  output logic [X_W-1:0] x_last_o,
  output logic [Y_W-1:0] y_last_o,
  output logic           empty_o
);

  logic [X_W:0] x_end;
  logic [Y_W:0] y_end;

  // One extra bit on the far-edge sums so x0+width-1 cannot wrap before clipping.
  always_comb begin
    x_end    = {1'b0, x0_i} + {1'b0, width_i} - 1'b1;
    y_end    = {1'b0, y0_i} + {1'b0, height_i} - 1'b1;
    x_last_o = X_W'(clip_min(32'(x_end), 32'(SCREEN_W - 1)));
    y_last_o = Y_W'(clip_min(32'(y_end), 32'(SCREEN_H - 1)));
    empty_o  = (width_i == '0) || (height_i == '0) ||
               ({1'b0, x0_i} >= (X_W+1)'(SCREEN_W)) ||
               ({1'b0, y0_i} >= (Y_W+1)'(SCREEN_H));
  end

endmodule

// File: rtl/rect_fill_scanner.sv
// Raster-scans a clipped rectangle and streams (x, y, colour) to a plot port
// with plot_ready backpressure and a start/done handshake.
// Optional build macro RECT_CHECKER_EN adds a two-colour checkerboard fill
// (inputs mode and colour_alt); without it the fill is always solid.
module rect_fill_scanner
  import rect_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [X_W-1:0]      width,
  input  logic [Y_W-1:0]      height,
  input  logic [COLOUR_W-1:0] colour_in,
`ifdef RECT_CHECKER_EN
  input  logic                mode,
  input  logic [COLOUR_W-1:0] colour_alt,
`endif
  input  logic                plot_ready,
  output logic                plot,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                busy,
  output logic                done
);

  state_t              state_q;
  logic                pend_q;
  logic                plot_q;
  logic                busy_q;
  logic                done_q;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [X_W-1:0]      x0_q;
  logic [X_W-1:0]      x_last_q;
  logic [Y_W-1:0]      y_last_q;
  logic [COLOUR_W-1:0] col_q;
`ifdef RECT_CHECKER_EN
  logic                mode_q;
  logic [COLOUR_W-1:0] alt_q;
`endif

  logic [X_W-1:0] x_last_c;
  logic [Y_W-1:0] y_last_c;
  logic           empty_c;

  rect_clip #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_clip (
    .x0_i     (x0),
    .y0_i     (y0),
    .width_i  (width),
    .height_i (height),
    .x_last_o (x_last_c),
    .y_last_o (y_last_c),
    .empty_o  (empty_c)
  );

  // Scan FSM: IDLE latches a request, RUN steps the raster on each accepted
  // pixel, DONE emits the completion pulse. An empty request waits one IDLE
  // cycle (pend_q) before DONE so its done lands two cycles after start.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      x0_q     <= '0;
      x_last_q <= '0;
      y_last_q <= '0;
      col_q    <= '0;
`ifdef RECT_CHECKER_EN
      mode_q   <= 1'b0;
      alt_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (pend_q) begin
            pend_q  <= 1'b0;
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (start) begin
            col_q    <= colour_in;
            x0_q     <= x0;
            x_last_q <= x_last_c;
            y_last_q <= y_last_c;
`ifdef RECT_CHECKER_EN
            mode_q   <= mode;
            alt_q    <= colour_alt;
`endif
            if (empty_c) begin
              pend_q <= 1'b1;
            end else begin
              state_q <= RUN;
              plot_q  <= 1'b1;
              busy_q  <= 1'b1;
              x_q     <= x0;
              y_q     <= y0;
            end
          end
        end
        RUN: begin
          if (plot_ready) begin
            if (x_q == x_last_q) begin
              if (y_q == y_last_q) begin
                state_q <= DONE;
                plot_q  <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                x_q     <= '0;
                y_q     <= '0;
              end else begin
                x_q <= x0_q;
                y_q <= y_q + 1'b1;
              end
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          plot_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign plot  = plot_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign x_out = x_q;
  assign y_out = y_q;

`ifdef RECT_CHECKER_EN
  assign colour_out = (mode_q && (x_q[0] ^ y_q[0])) ? alt_q : col_q;
`else
  assign colour_out = col_q;
`endif

endmodule

// File: tb/tb_rect_fill_scanner.sv
// Self-checking bench for rect_fill_scanner: a queue-based pixel model predicts
// every output each cycle, plus directed literal checks on key scenarios.
module tb_rect_fill_scanner;

`ifdef RECT_CHECKER_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int SW = 160;
  localparam int SH = 120;

  logic       clk = 1'b0;
  logic       resetn, start, plot_ready, mode;
  logic [7:0] x0, width;
  logic [6:0] y0, height;
  logic [2:0] colour_in, colour_alt;
  logic       plot, busy, done;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;

  rect_fill_scanner dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .x0         (x0),
    .y0         (y0),
    .width      (width),
    .height     (height),
    .colour_in  (colour_in),
`ifdef RECT_CHECKER_EN
    .mode       (mode),
    .colour_alt (colour_alt),
`endif
    .plot_ready (plot_ready),
    .plot       (plot),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int c;} pix_t;

  pix_t eq[$];    // pixels still to be delivered, in raster order
  pix_t acc[$];   // pixels the DUT delivered (accepted) in this transaction
  int   tests = 0, fails = 0, cyc = 0;
  bit   mvalid = 1'b0, pend = 1'b0, exp_done = 1'b0;
  int   lc = 0;
  int   plot_cycles = 0, last_plot_cyc = 0, done_cyc = 0, done_cnt = 0;
  int   start_cyc = 0, ready_mode = 0, pidx = 0;

  task automatic chk(input string nm, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  function automatic int accf(input int i, input int f);
    if (i >= acc.size()) return -1;
    return (f == 0) ? acc[i].x : (f == 1) ? acc[i].y : acc[i].c;
  endfunction

  // Every visible pixel of the rectangle, row by row.
  function automatic void build(input int ax, ay, aw, ah, ac, am, aal);
    eq.delete();
    for (int yy = ay; yy < ay + ah && yy < SH; yy++)
      for (int xx = ax; xx < ax + aw && xx < SW; xx++)
        eq.push_back('{xx, yy, (am != 0 && ((xx ^ yy) & 1) != 0) ? aal : ac});
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: advances on each clock edge from the bench inputs only.
  initial forever begin
    bit nd;
    @(posedge clk);
    if (!resetn) begin
      eq.delete(); pend = 1'b0; exp_done = 1'b0; lc = 0; mvalid = 1'b1;
    end else if (mvalid) begin
      nd = 1'b0;
      if (eq.size() > 0) begin
        if (plot_ready) begin
          void'(eq.pop_front());
          if (eq.size() == 0) nd = 1'b1;
        end
      end else if (pend) begin
        pend = 1'b0; nd = 1'b1;
      end else if (!exp_done && start) begin
        lc = int'(colour_in);
        build(int'(x0), int'(y0), int'(width), int'(height), int'(colour_in),
              CHK ? int'(mode) : 0, int'(colour_alt));
        if (eq.size() == 0) pend = 1'b1;
      end
      exp_done = nd;
    end
  end

  // Per-cycle comparison against the model, plus logging for directed checks.
  initial forever begin
    bit ep; int ex, ey, ec;
    @(negedge clk);
    if (mvalid) begin
      ep = (eq.size() > 0);
      if (ep) begin ex = eq[0].x; ey = eq[0].y; ec = eq[0].c; end
      else begin ex = 0; ey = 0; ec = lc; end
      tests++;
      if (plot !== ep || busy !== ep || done !== exp_done || x_out !== 8'(ex) ||
          y_out !== 7'(ey) || colour_out !== 3'(ec)) begin
        fails++;
        $display("FAIL cycle %0d: got plot=%b busy=%b done=%b x=%0d y=%0d c=%0d, want plot=%b busy=%b done=%b x=%0d y=%0d c=%0d",
                 cyc, plot, busy, done, x_out, y_out, colour_out, ep, ep, exp_done, ex, ey, ec);
      end
      if (plot === 1'b1 && plot_ready === 1'b1)
        acc.push_back('{int'(x_out), int'(y_out), int'(colour_out)});
      if (plot === 1'b1) begin plot_cycles++; last_plot_cyc = cyc; end
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    end
  end

  // plot_ready driver: tied high, random, or the 1,0,0 repeating pattern.
  initial forever begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       plot_ready = 1'b1;
      1:       plot_ready = 1'($urandom % 2);
      default: plot_ready = ((pidx % 3) == 0);
    endcase
    pidx++;
  end

  task automatic clr_log();
    acc.delete();
    plot_cycles = 0;
  endtask

  task automatic do_start(input int ax, ay, aw, ah, ac, am, aal);
    @(posedge clk);
    #1;
    x0 = 8'(ax); y0 = 7'(ay); width = 8'(aw); height = 7'(ah);
    colour_in = 3'(ac); mode = 1'(am); colour_alt = 3'(aal);
    start = 1'b1; start_cyc = cyc; pidx = -1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x0 = 8'($urandom); y0 = 7'($urandom); width = 8'($urandom); height = 7'($urandom);
  endtask

  task automatic wait_done(input string nm, input int budget, input bit inject);
    int n = 0; bit seen = 1'b0; int d0 = done_cnt;
    while (!seen && n < budget) begin
      @(posedge clk);
      #1;
      start = inject && ($urandom % 6 == 0);
      if (start) begin
        x0 = 8'($urandom); y0 = 7'($urandom); width = 8'($urandom_range(1, 5));
        height = 7'($urandom_range(1, 5)); colour_in = 3'($urandom);
      end
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      n++;
    end
    #1;
    start = 1'b0;
    chk({nm, "_done_pulses"}, done_cnt - d0, 1);
  endtask

  initial begin
    int cexp[4];
    resetn = 1'b0; start = 1'b0; plot_ready = 1'b1; mode = 1'b0;
    x0 = '0; y0 = '0; width = '0; height = '0; colour_in = '0; colour_alt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_plot", int'(plot), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_xy", int'(x_out) + int'(y_out) + int'(colour_out) + int'(done), 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Clipped box at the bottom-right corner.
    clr_log();
    do_start(155, 117, 10, 10, 5, 0, 0);
    wait_done("clip", 200, 1'b0);
    chk("clip_count", acc.size(), 15);
    chk("clip_first_x", accf(0, 0), 155);
    chk("clip_first_y", accf(0, 1), 117);
    chk("clip_wrap_x", accf(5, 0), 155);
    chk("clip_wrap_y", accf(5, 1), 118);
    chk("clip_last_x", accf(14, 0), 159);
    chk("clip_last_y", accf(14, 1), 119);
    chk("clip_done_lat", done_cyc - last_plot_cyc, 1);

    // Backpressure with plot_ready = 1,0,0,1,0,0,...
    clr_log();
    ready_mode = 2;
    do_start(3, 4, 2, 2, 2, 0, 0);
    wait_done("bp", 100, 1'b0);
    ready_mode = 0;
    chk("bp_count", acc.size(), 4);
    chk("bp_p0", accf(0, 0) * 100 + accf(0, 1), 304);
    chk("bp_p1", accf(1, 0) * 100 + accf(1, 1), 404);
    chk("bp_p2", accf(2, 0) * 100 + accf(2, 1), 305);
    chk("bp_p3", accf(3, 0) * 100 + accf(3, 1), 405);
    chk("bp_plot_cycles", plot_cycles, 10);

    // Empty regions: zero width, then x0 off screen.
    clr_log();
    do_start(10, 10, 0, 5, 1, 0, 0);
    wait_done("empty_w", 20, 1'b0);
    chk("empty_w_plots", plot_cycles, 0);
    chk("empty_w_done_lat", done_cyc - start_cyc, 2);
    clr_log();
    do_start(200, 10, 5, 5, 1, 0, 0);
    wait_done("empty_x", 20, 1'b0);
    chk("empty_x_plots", plot_cycles, 0);
    chk("empty_x_done_lat", done_cyc - start_cyc, 2);

    // Reset during the 5th plot cycle of a 10x10 box.
    clr_log();
    begin
      int d0;
      d0 = done_cnt;
      do_start(20, 20, 10, 10, 6, 0, 0);
      repeat (4) @(posedge clk);
      #1;
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      @(negedge clk);
      chk("rst_mid_plot", int'(plot), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_xy", int'(x_out) + int'(y_out), 0);
      repeat (5) @(negedge clk);
      chk("rst_mid_no_done", done_cnt - d0, 0);
      chk("rst_mid_plots", plot_cycles, 5);
    end

    // 2x2 checker (solid in the default build), with a stray start during RUN.
    clr_log();
    do_start(0, 0, 2, 2, 7, 1, 0);
    start = 1'b1; x0 = 8'd50; y0 = 7'd50; width = 8'd3; height = 7'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("chk", 50, 1'b0);
    cexp = CHK ? '{7, 0, 0, 7} : '{7, 7, 7, 7};
    chk("chk_count", acc.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("chk_colour%0d", i), accf(i, 2), cexp[i]);

    // Randomized rectangles, random backpressure, stray start pulses.
    for (int t = 0; t < 40; t++) begin
      ready_mode = int'($urandom % 2);
      clr_log();
      do_start(($urandom % 8 == 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 159)),
               ($urandom % 8 == 0) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 119)),
               int'($urandom_range(0, 12)), int'($urandom_range(0, 9)),
               int'($urandom % 8), int'($urandom % 2), int'($urandom % 8));
      wait_done($sformatf("rand%0d", t), 3000, 1'b1);
    end
    ready_mode = 0;

    // Full-screen clear.
    clr_log();
    do_start(0, 0, 160, 120, 4, 0, 0);
    wait_done("full", 20000, 1'b0);
    chk("full_plot_cycles", plot_cycles, 19200);
    chk("full_accepted", acc.size(), 19200);
    chk("full_last_x", accf(19199, 0), 159);
    chk("full_last_y", accf(19199, 1), 119);
    chk("full_done_lat", done_cyc - last_plot_cyc, 1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rect_fill_scanner.md
Name: rect_fill_scanner

Overview:
Parametrised successor to the full-screen clear counter. It raster-scans any rectangle and streams pixel coordinates plus colour to the VGA adapter's plot port. The rectangle is clipped to screen bounds, scanning is started by a start/done handshake, and the consumer can stall it with plot_ready. It sits between the game FSM and the VGA adapter and serves screen clear, sprite erase and box draw.

Parameters:
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
SCREEN_W, 160, visible columns; x valid range 0..SCREEN_W-1
SCREEN_H, 120, visible rows; y valid range 0..SCREEN_H-1
COLOUR_W, 3, colour width

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
start  in  1  one-cycle request; sampled in IDLE only
x0  in  X_W  rectangle left column
y0  in  Y_W  rectangle top row
width  in  X_W  columns; 0 means empty region
height  in  Y_W  rows; 0 means empty region
colour_in  in  COLOUR_W  fill colour, latched on start
plot_ready  in  1  consumer accepts the current pixel this cycle
plot  out  1  x_out, y_out and colour_out are valid
x_out  out  X_W  current column
y_out  out  Y_W  current row
colour_out  out  COLOUR_W  current colour
busy  out  1  high in RUN
done  out  1  one-cycle pulse when the scan completes

Behaviour:
- Clock and reset: single clock, clk. resetn is synchronous and active-low. While resetn=0 at a clk edge: state=IDLE, and plot, busy, done, x_out, y_out and colour_out are all 0. Reset is honoured mid-scan; the scan is abandoned and no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE to RUN, on start=1:
  - latch x0, y0 and colour_in
  - compute x_last = min(x0+width-1, SCREEN_W-1) and y_last = min(y0+height-1, SCREEN_H-1), using X_W+1 / Y_W+1 bit arithmetic so there is no wrap
  - load x_out=x0, y_out=y0
- IDLE to DONE, on start=1 with an empty region: width==0, height==0, x0>=SCREEN_W or y0>=SCREEN_H. In this case plot never asserts.
- RUN:
  - plot=1 and busy=1.
  - A pixel is accepted on a cycle with plot=1 and plot_ready=1.
  - On acceptance, if x_out!=x_last then x_out+1. Otherwise x_out=x0 and y_out+1.
  - When the pixel at (x_last, y_last) is accepted, go to DONE and deassert plot the next cycle.
  - If plot_ready=0, all outputs hold stable.
- DONE: done=1 for exactly one cycle, then IDLE. plot=0 and busy=0. x_out and y_out return to 0.
- start during RUN or DONE is ignored; there is no queuing.
- Latency:
  - start at cycle N gives the first plot at N+1.
  - With plot_ready tied high, a clipped W×H region yields W*H plot cycles, then done one cycle later.
  - An empty region gives done at N+2 (IDLE, then DONE).
- Inputs other than plot_ready are don't-care outside the start cycle.

Optional Feature:
Macro RECT_CHECKER_EN.
- Defined:
  - adds input mode (1 bit) and input colour_alt (COLOUR_W), both latched on start
  - mode=1: colour_out = colour_in when (x_out^y_out)[0]==0, else colour_alt
  - mode=0: solid fill
- Undefined: those ports are absent and colour_out is always the latched colour_in.
- Timing and handshake are identical in both builds.

Decomposition:
- Package rect_pkg holds:
  - the state enum (IDLE/RUN/DONE)
  - default SCREEN_W and SCREEN_H
  - the clipping min helper function
- One sub-module is natural: rect_clip, which is combinational and produces x_last, y_last and the empty flag from x0/y0/width/height.
- The counter FSM stays in the top module.

Test Plan:
- Reset mid-scan: start a 10×10 box, then pull resetn=0 at the 5th plot → next cycle plot=0, busy=0, x_out=y_out=0, and no done pulse.
- Full clear: x0=0, y0=0, width=160, height=120, plot_ready=1 → 19200 plot cycles; last pixel (159,119); done exactly one cycle later.
- Clipped box: x0=155, y0=117, width=10, height=10 → pixels x 155..159, y 117..119, 15 plots in raster order; the row wrap returns x to 155.
- Backpressure: x0=3, y0=4, 2×2, plot_ready toggling 1,0,0,1,… → exactly 4 accepted pixels (3,4), (4,4), (3,5), (4,5); outputs stable on stall cycles.
- Empty region: width=0 (and separately x0=200) → plot never asserts; done high at start+2 for one cycle.
- Checker (with RECT_CHECKER_EN): 2×2 at (0,0), colour_in=3'b111, colour_alt=3'b000 → colours 7, 0, 0, 7; start pulsed during RUN is ignored.
